// File: rtl/mod5_serial_tx.sv
// MSB-first serial word source for the divisibility-by-5 detector, with valid/ready intake.
// Define MOD5_CHECK_EN to build the running-remainder reference tracker (exp_rem/exp_q).
module mod5_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic [2:0]       exp_rem,
  output logic             exp_q
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_STEP = CW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          cnt_d   = CNT_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CNT_STEP;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only; no input reaches an output combinationally.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SHIFT);
    out       = out_valid & sr_q[WIDTH-1];
    out_first = out_valid && (cnt_q == CNT_TOP);
    out_last  = out_valid && (cnt_q == '0);
    busy      = out_valid;
  end

`ifdef MOD5_CHECK_EN
  logic [2:0] rem_q, rem_d;
  logic [3:0] rem_dbl;

  // Idle zeros are folded in too, since the detector consumes the line every cycle.
  always_comb begin
    rem_dbl = {rem_q, 1'b0} + {3'b000, out};
    rem_d   = (rem_dbl >= 4'd5) ? 3'(rem_dbl - 4'd5) : rem_dbl[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign exp_rem = rem_q;
  assign exp_q   = (rem_q == 3'd0);
`else
  assign exp_rem = '0;
  assign exp_q   = 1'b0;
`endif

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Scoreboard bench for mod5_serial_tx: handshakes push expected line cycles, a negedge monitor pops and checks.
module tb_mod5_serial_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic         busy;
  logic [2:0]   exp_rem;
  logic         exp_q;

  mod5_serial_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last (out_last),
    .busy     (busy),
    .exp_rem  (exp_rem),
    .exp_q    (exp_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit b;
    bit first;
    bit last;
  } ent_t;

  ent_t sb[$];
  bit   cur_idle;
  bit   cur_bit;
  int   rem;
  int   total;
  int   bad;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int exp_rem_ref();
`ifdef MOD5_CHECK_EN
    return rem;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_q_ref();
`ifdef MOD5_CHECK_EN
    return (rem == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Reference: a frame accepted at an idle edge occupies the next W cycles, MSB first;
  // the detector remainder absorbs the line value (0 when idle) at every edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      cur_idle = 1'b1;
      cur_bit  = 1'b0;
      rem      = 0;
    end else begin
      rem = (2 * rem + int'(cur_bit)) % 5;
      if (cur_idle && in_valid) begin
        for (int i = W - 1; i >= 0; i--) begin
          ent_t e;
          e.b     = in_data[i];
          e.first = (i == W - 1);
          e.last  = (i == 0);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        ent_t e;
        chk("exp_rem", exp_rem, exp_rem_ref());
        chk("exp_q", exp_q, exp_q_ref());
        if (sb.size() > 0) begin
          e = sb.pop_front();
          cur_idle = 1'b0;
          cur_bit  = e.b;
        end else begin
          e.b = 1'b0; e.first = 1'b0; e.last = 1'b0;
          cur_idle = 1'b1;
          cur_bit  = 1'b0;
        end
        chk("in_ready", in_ready, int'(cur_idle));
        chk("out_valid", out_valid, int'(!cur_idle));
        chk("busy", busy, int'(!cur_idle));
        chk("out", out, int'(e.b));
        chk("out_first", out_first, int'(e.first));
        chk("out_last", out_last, int'(e.last));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit keep);
    bit taken;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    taken    = 1'b0;
    for (int i = 0; i < 4 * W && !taken; i++) begin
      @(posedge clk);
      if (cur_idle) taken = 1'b1;
    end
    if (!taken) chk("handshake_timeout", 0, 1);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int      seq[4];
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_exp_rem", exp_rem, 0);
`ifdef MOD5_CHECK_EN
    chk("rst_exp_q", exp_q, 1);
`else
    chk("rst_exp_q", exp_q, 0);
`endif

    send(8'h05, 1'b0);
    repeat (12) @(negedge clk);

    // 0x07 from remainder 0, then idle zeros: 2, 4, 3, 1, 2
    pulse_reset();
    send(8'h07, 1'b0);
    repeat (W) @(posedge clk);
    #1;
`ifdef MOD5_CHECK_EN
    chk("rem07_end", exp_rem, 2);
    chk("q07_end", exp_q, 0);
    seq = '{4, 3, 1, 2};
    foreach (seq[k]) begin
      @(posedge clk);
      #1 chk("rem07_idle", exp_rem, seq[k]);
    end
`else
    chk("rem07_end", exp_rem, 0);
    chk("q07_end", exp_q, 0);
`endif

    send(8'h0A, 1'b1);
    send(8'h0F, 1'b0);
    repeat (W + 4) @(negedge clk);

    send(8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_exp_rem", exp_rem, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    send(8'hB3, 1'b0);
    repeat (W + 2) @(negedge clk);

    repeat (150) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom), bit'($urandom_range(0, 1)));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
